// File: rtl/interleave_checker.sv
// Purpose : checks that each stim edge ripples through tap[0..N_TAPS-1] in index
//           order, with the expected polarity and a bounded gap between edges.
// Latency : inputs are registered twice (sample + previous sample). Every result
//           output is registered, so it changes two clocks after the input change.
// Backpressure: none. The block only observes. Once an error is latched, the
//           block ignores all later edges until reset or clr.
//
// Ports:
//   clk, reset, clr    rising-edge clock, synchronous active-high reset and clear
//   stim, tap          stimulus launched into the chain and the taps coming back
//   busy, pass         propagation in flight / one-cycle pulse on completion
//   pass_count         number of completed propagations (saturating)
//   last_lat           cycles from the stim edge to the last tap for the latest pass
//   err_order, err_timeout, err_overrun, err_tap   sticky error flags and the tap index
module interleave_checker #(
  parameter int                N_TAPS   = 5,
  parameter logic [N_TAPS-1:0] INV_MASK = '0,
  parameter int                MAX_LAT  = 15,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              stim,
  input  logic [N_TAPS-1:0] tap,
  output logic              busy,
  output logic              pass,
  output logic [CNT_W-1:0]  pass_count,
  output logic [7:0]        last_lat,
  output logic              err_order,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic [7:0]        err_tap
);

  localparam int KW = $clog2(N_TAPS + 1);
  localparam int SW = $clog2(MAX_LAT + 2);
  localparam logic [KW-1:0] K_DONE  = KW'(N_TAPS);
  localparam logic [SW-1:0] SEG_MAX = SW'(MAX_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t              state;
  logic                stim_q, stim_p;
  logic [N_TAPS-1:0]   tap_q, tap_p;
  logic [KW-1:0]       k;
  logic [SW-1:0]       seg_cnt;
  logic [7:0]          tot_cnt;

  logic                stim_edge;
  logic [N_TAPS-1:0]   tog, good, in_run, bad;
  logic [KW-1:0]       base, run_m, k_sum;
  logic                run_on;
  logic [7:0]          bad_idx;
  logic [SW-1:0]       seg_inc;
  logic [7:0]          tot_inc;
  logic                timeout;
  logic [CNT_W-1:0]    cnt_inc;

  // Classify this sample's tap toggles. The run of correctly polarised toggles
  // that starts at the next expected tap is progress. Any other toggle is an
  // ordering error. In IDLE with no stim edge, every toggle is spurious.
  always_comb begin
    stim_edge = stim_q ^ stim_p;
    tog       = tap_q ^ tap_p;
    good      = ~(tap_q ^ {N_TAPS{stim_q}} ^ INV_MASK);
    base      = (state == WAIT) ? k : '0;
    in_run    = '0;
    run_m     = '0;
    run_on    = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      if (i >= int'(base)) begin
        if (run_on && tog[i] && good[i]) begin
          in_run[i] = 1'b1;
          run_m     = run_m + KW'(1);
        end else begin
          run_on = 1'b0;
        end
      end
    end
    k_sum   = base + run_m;
    bad     = (state == IDLE && !stim_edge) ? tog : (tog & ~in_run);
    bad_idx = '0;
    for (int i = N_TAPS - 1; i >= 0; i--) begin
      if (bad[i]) bad_idx = 8'(i);
    end
    seg_inc = seg_cnt + SW'(1);
    tot_inc = (tot_cnt == 8'hFF) ? tot_cnt : tot_cnt + 8'd1;
    timeout = (run_m == '0) && (seg_inc > SEG_MAX);
    cnt_inc = (&pass_count) ? pass_count : pass_count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      // Preload both sample stages with the live inputs so that no edge appears
      // on the first cycle after the reset or clear.
      stim_q      <= stim;
      stim_p      <= stim;
      tap_q       <= tap;
      tap_p       <= tap;
      state       <= IDLE;
      k           <= '0;
      seg_cnt     <= '0;
      tot_cnt     <= '0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      pass_count  <= '0;
      last_lat    <= '0;
      err_order   <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      err_tap     <= '0;
    end else begin
      stim_q <= stim;
      stim_p <= stim_q;
      tap_q  <= tap;
      tap_p  <= tap_q;
      pass   <= 1'b0;
      case (state)
        IDLE: begin
          if (|bad) begin
            state     <= ERR;
            err_order <= 1'b1;
            err_tap   <= bad_idx;
          end else if (stim_edge) begin
            if (k_sum == K_DONE) begin
              // The whole chain arrived together with the stim edge.
              pass       <= 1'b1;
              pass_count <= cnt_inc;
              last_lat   <= '0;
            end else begin
              state   <= WAIT;
              busy    <= 1'b1;
              k       <= k_sum;
              seg_cnt <= '0;
              tot_cnt <= '0;
            end
          end
        end
        WAIT: begin
          if (stim_edge || (|bad) || timeout) begin
            state       <= ERR;
            busy        <= 1'b0;
            err_overrun <= stim_edge;
            err_order   <= |bad;
            err_timeout <= timeout;
            // An overrun reports the tap being waited on, even when the same
            // sample also contains an ordering error.
            err_tap     <= (stim_edge || !(|bad)) ? 8'(k) : bad_idx;
          end else if (k_sum == K_DONE) begin
            state      <= IDLE;
            busy       <= 1'b0;
            k          <= '0;
            pass       <= 1'b1;
            pass_count <= cnt_inc;
            last_lat   <= tot_inc;
          end else begin
            k       <= k_sum;
            seg_cnt <= (run_m != '0) ? '0 : seg_inc;
            tot_cnt <= tot_inc;
          end
        end
        ERR: begin
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interleave_checker.sv
module tb_interleave_checker;
  localparam int N  = 5;
  localparam int ML = 15;
  typedef int sched_t [N];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, clr, stim;
  logic [N-1:0] tap;
  logic         busy, pass, err_order, err_timeout, err_overrun;
  logic [15:0]  pass_count;
  logic [7:0]   last_lat, err_tap;

  logic         istim;
  logic [N-1:0] itap;
  logic         ibusy, ipass, ierr_order, ierr_timeout, ierr_overrun;
  logic [15:0]  ipass_count;
  logic [7:0]   ilast_lat, ierr_tap;

  int checks  = 0;
  int errors  = 0;
  int npass   = 0;
  int exp_cnt = 0;

  interleave_checker #(.N_TAPS(N), .INV_MASK(5'b00000), .MAX_LAT(ML), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .clr(clr), .stim(stim), .tap(tap),
    .busy(busy), .pass(pass), .pass_count(pass_count), .last_lat(last_lat),
    .err_order(err_order), .err_timeout(err_timeout), .err_overrun(err_overrun),
    .err_tap(err_tap)
  );

  interleave_checker #(.N_TAPS(N), .INV_MASK(5'b00001), .MAX_LAT(ML), .CNT_W(16)) u_inv (
    .clk(clk), .reset(reset), .clr(clr), .stim(istim), .tap(itap),
    .busy(ibusy), .pass(ipass), .pass_count(ipass_count), .last_lat(ilast_lat),
    .err_order(ierr_order), .err_timeout(ierr_timeout), .err_overrun(ierr_overrun),
    .err_tap(ierr_tap)
  );

  always @(negedge clk) if (pass) npass++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stim toggles at relative cycle 0. tap[i] toggles at cycle tt[i] (-1 means never).
  // A change driven at cycle c shows up on the outputs from cycle c+2.
  task automatic run(input sched_t tt, input int ov_t, input int to_d, input int busy_c,
                     input int end_c);
    for (int c = 0; c <= end_c; c++) begin
      if (c == 0) stim = ~stim;
      if (c == ov_t) stim = ~stim;
      for (int i = 0; i < N; i++) if (tt[i] == c) tap[i] = ~tap[i];
      if (to_d >= 0 && c == to_d + 1) chk("timeout_early", err_timeout, 0);
      if (to_d >= 0 && c == to_d + 2) chk("timeout_rise", err_timeout, 1);
      if (c == busy_c) chk("busy_mid", busy, 1);
      tick();
    end
  endtask

  task automatic do_clr();
    tap = {N{stim}};
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_cnt = 0;
    chk("clr:flags", {err_order, err_timeout, err_overrun}, 0);
    chk("clr:err_tap", err_tap, 0);
    chk("clr:pass_count", pass_count, 0);
    tick();
  endtask

  task automatic scn_pass(input string tag, input sched_t s);
    int np0;
    np0 = npass;
    run(s, -1, -1, (s[N-1] >= 1) ? 2 : -1, s[N-1] + 4);
    exp_cnt++;
    chk({tag, ":pass_pulses"}, npass - np0, 1);
    chk({tag, ":pass_count"}, pass_count, exp_cnt);
    chk({tag, ":last_lat"}, last_lat, s[N-1]);
    chk({tag, ":flags"}, {err_order, err_timeout, err_overrun}, 0);
    chk({tag, ":busy"}, busy, 0);
  endtask

  task automatic expect_err(input string tag, input logic o, input logic t, input logic v,
                            input int idx, input int np0);
    chk({tag, ":flags"}, {err_order, err_timeout, err_overrun}, {o, t, v});
    chk({tag, ":err_tap"}, err_tap, idx);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":no_pass"}, npass - np0, 0);
    do_clr();
  endtask

  initial begin
    sched_t       s;
    int           t, j, p, ov, np0, lo;
    logic [N-1:0] mask;

    reset = 1'b1; clr = 1'b0; stim = 1'b0; tap = '0;
    istim = 1'b0; itap = '0;        // tap0 of u_inv is deliberately inconsistent
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset:flags", {err_order, err_timeout, err_overrun, busy, pass}, 0);
    chk("reset:pass_count", pass_count, 0);
    chk("reset:last_lat", last_lat, 0);
    chk("reset:err_tap", err_tap, 0);

    // Polarity: with INV_MASK[0]=1, tap0 ends equal to stim, so it is wrong.
    istim = 1'b1; itap = 5'b00001;
    repeat (4) tick();
    chk("inv_pol:err_order", ierr_order, 1);
    chk("inv_pol:err_tap", ierr_tap, 0);
    chk("inv_pol:busy", ibusy, 0);
    chk("inv_pol:other", {ierr_timeout, ierr_overrun, ipass}, 0);
    chk("inv_pol:pass_count", ipass_count, 0);
    istim = 1'b0; itap = 5'b00001;
    do_clr();
    istim = 1'b1;
    tick();
    itap = 5'b11110;
    repeat (4) tick();
    chk("inv_clean:pass_count", ipass_count, 1);
    chk("inv_clean:last_lat", ilast_lat, 1);
    chk("inv_clean:err_order", ierr_order, 0);

    scn_pass("basic_rise", '{1, 3, 5, 7, 9});
    scn_pass("basic_fall", '{1, 3, 5, 7, 9});
    scn_pass("simul", '{0, 0, 0, 2, 2});
    scn_pass("all_at_once", '{0, 0, 0, 0, 0});
    scn_pass("max_gap", '{16, 32, 33, 49, 50});

    np0 = npass;
    run('{1, -1, 3, -1, -1}, -1, -1, -1, 7);
    expect_err("order_dir", 1, 0, 0, 2, np0);

    np0 = npass;
    run('{1, -1, -1, -1, -1}, -1, 1 + ML + 1, -1, 1 + ML + 4);
    expect_err("timeout_dir", 0, 1, 0, 1, np0);

    np0 = npass;
    run('{1, 2, 3, -1, -1}, 5, -1, -1, 9);
    expect_err("overrun_dir", 0, 0, 1, 3, np0);

    // Reset while k=2, with the taps made consistent during reset.
    run('{1, 2, -1, -1, -1}, -1, -1, 2, 5);
    chk("rst:busy_before", busy, 1);
    reset = 1'b1;
    tap = {N{stim}};
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst:flags", {err_order, err_timeout, err_overrun, busy, pass}, 0);
    chk("rst:pass_count", pass_count, 0);
    repeat (3) tick();
    chk("rst:no_spurious", {err_order, busy}, 0);
    exp_cnt = 0;
    scn_pass("rst_run", '{1, 2, 3, 4, 5});

    for (int it = 0; it < 40; it++) begin
      s = '{-1, -1, -1, -1, -1};
      t = 0;
      np0 = npass;
      case ($urandom_range(0, 4))
        0: begin
          for (int i = 0; i < N; i++) begin
            t += ($urandom_range(0, 7) == 0) ? ML + 1 : int'($urandom_range(0, 4));
            s[i] = t;
          end
          scn_pass("rnd_pass", s);
        end
        1: begin
          j = int'($urandom_range(0, N - 1));
          for (int i = 0; i < j; i++) begin t += int'($urandom_range(0, 4)); s[i] = t; end
          run(s, -1, t + ML + 1, -1, t + ML + 4);
          expect_err("rnd_timeout", 0, 1, 0, j, np0);
        end
        2: begin
          j = int'($urandom_range(0, N - 2));
          for (int i = 0; i < j; i++) begin t += int'($urandom_range(0, 4)); s[i] = t; end
          p = int'($urandom_range(j + 1, N - 1));
          t += int'($urandom_range(0, 4));
          s[p] = t;
          run(s, -1, -1, -1, t + 4);
          expect_err("rnd_order", 1, 0, 0, p, np0);
        end
        3: begin
          j = int'($urandom_range(0, N - 1));
          for (int i = 0; i < j; i++) begin t += int'($urandom_range(0, 4)); s[i] = t; end
          ov = t + int'($urandom_range(1, 4));
          run(s, ov, -1, -1, ov + 4);
          expect_err("rnd_overrun", 0, 0, 1, j, np0);
        end
        default: begin
          mask = 5'($urandom_range(1, 31));
          tap = tap ^ mask;
          repeat (4) tick();
          lo = 0;
          for (int i = N - 1; i >= 0; i--) if (mask[i]) lo = i;
          expect_err("rnd_spurious", 1, 0, 0, lo, np0);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
